// File: rtl/ps_fb_writer.sv
// Frame-buffer writer: pulls pixels from an upstream FIFO under a 2-pixel credit limit
// and writes them in raster order with a valid/ready handshake and line/frame pulses.
module ps_fb_writer #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_obuf_empty,
  input  logic                  i_obuf_almostempty,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  output logic                  o_obuf_rd,
  input  logic                  i_fb_ready,
  output logic                  o_fb_wr,
  output logic [ADDR_WIDTH-1:0] o_fb_addr,
  output logic [DATA_WIDTH-1:0] o_fb_data,
  output logic                  o_line_done,
  output logic                  o_frame_done
);

  localparam int CW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int RW = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_LENGTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINE_COUNT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                r_state;
  logic                  r_rd;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_skid_v;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_line_done;
  logic                  r_frame_done;

  logic                  w_accept;
  logic [1:0]            w_credit_after;
  logic                  w_issue;
  logic                  w_wr_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_skid_v_nxt;
  logic [DATA_WIDTH-1:0] w_skid_data_nxt;
  logic [1:0]            w_credit_nxt;

  // r_rd set means the FIFO word is presented this cycle and captured at the coming edge.
  assign w_accept       = r_wr & i_fb_ready;
  assign w_credit_after = {1'b0, r_wr} + {1'b0, r_skid_v} + {1'b0, r_rd} - {1'b0, w_accept};
  assign w_issue        = !i_flush && !i_obuf_empty && (w_credit_after < 2'd2) &&
                          (!i_obuf_almostempty || !r_rd);
  assign w_credit_nxt   = {1'b0, w_wr_nxt} + {1'b0, w_skid_v_nxt} + {1'b0, w_issue};

  always_comb begin
    w_wr_nxt        = r_wr;
    w_data_nxt      = r_data;
    w_skid_v_nxt    = r_skid_v;
    w_skid_data_nxt = r_skid_data;
    if (!r_wr || w_accept) begin
      if (r_skid_v) begin
        w_wr_nxt        = 1'b1;
        w_data_nxt      = r_skid_data;
        w_skid_v_nxt    = r_rd;
        w_skid_data_nxt = i_obuf_data;
      end else if (r_rd) begin
        w_wr_nxt   = 1'b1;
        w_data_nxt = i_obuf_data;
      end else begin
        w_wr_nxt = 1'b0;
      end
    end else if (r_rd) begin
      w_skid_v_nxt    = 1'b1;
      w_skid_data_nxt = i_obuf_data;
    end else begin
      w_skid_v_nxt = r_skid_v;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_skid_v     <= 1'b0;
      r_skid_data  <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (i_flush) begin
      r_state      <= S_IDLE;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_skid_v     <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rd        <= w_issue;
      r_wr        <= w_wr_nxt;
      r_data      <= w_data_nxt;
      r_skid_v    <= w_skid_v_nxt;
      r_skid_data <= w_skid_data_nxt;
      case (r_state)
        S_IDLE:   r_state <= w_issue ? S_STREAM : S_IDLE;
        S_STREAM: r_state <= (w_credit_nxt == 2'd0) ? S_IDLE : S_STREAM;
        default:  r_state <= S_IDLE;
      endcase
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      // Address tracks row*LINE_LENGTH+col by stepping, wrapping only at frame end.
      if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col       <= '0;
          r_line_done <= 1'b1;
          if (r_row == ROW_LAST) begin
            r_row        <= '0;
            r_addr       <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_row  <= r_row + RW'(1);
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end else begin
          r_col  <= r_col + CW'(1);
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign o_obuf_rd    = r_rd;
  assign o_fb_wr      = r_wr;
  assign o_fb_addr    = r_addr;
  assign o_fb_data    = r_data;
  assign o_line_done  = r_line_done;
  assign o_frame_done = r_frame_done;

endmodule
